// File: rtl/datapath_pkg.sv
// Shared constants for the CDEC datapath core: selector codes, FSM states,
// ALU opcodes and flag bit positions.
package datapath_pkg;

    localparam int ALUOP_W = 4;

    localparam int FLG_CY = 1;
    localparam int FLG_Z  = 2;
    localparam int FLG_S  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_ADC  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_SBB  = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_NOT  = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_PASA = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_PASB = 4'd9;
    localparam logic [ALUOP_W-1:0] ALU_INC  = 4'd10;
    localparam logic [ALUOP_W-1:0] ALU_DEC  = 4'd11;
    localparam logic [ALUOP_W-1:0] ALU_SHL  = 4'd12;
    localparam logic [ALUOP_W-1:0] ALU_SHR  = 4'd13;

    function automatic int src_r(int ngpr);    return ngpr + 1; endfunction
    function automatic int src_mem(int ngpr);  return ngpr + 2; endfunction
    function automatic int src_flg(int ngpr);  return ngpr + 3; endfunction
    function automatic int src_ones(int ngpr); return ngpr + 4; endfunction

    function automatic int dst_mar(int ngpr);  return ngpr + 1; endfunction
    function automatic int dst_wdr(int ngpr);  return ngpr + 2; endfunction
    function automatic int dst_t(int ngpr);    return ngpr + 3; endfunction
    function automatic int dst_i(int ngpr);    return ngpr + 4; endfunction
    function automatic int dst_memw(int ngpr); return ngpr + 5; endfunction

endpackage

// File: rtl/dp_mem_if.sv
// Memory handshake FSM: sequences req/ack transactions, captures write
// data at request time and produces uop_ready for the controller.
module dp_mem_if
    import datapath_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_uop_valid,
    input  logic          i_src_mem,
    input  logic          i_dst_memw,
    input  logic          i_mem_ack,
    input  logic [DW-1:0] i_xbus,
    output logic          o_uop_ready,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_wdata,
    output state_t        o_state
);

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_wdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_uop_valid && i_src_mem)       w_next = RD_WAIT;
                else if (i_uop_valid && i_dst_memw) w_next = WR_WAIT;
            end
            RD_WAIT, WR_WAIT: begin
                if (i_mem_ack) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // req/we decode straight from the async-reset state so reset drops them at once
    always_comb begin
        o_uop_ready = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        unique case (r_state)
            IDLE:    o_uop_ready = i_uop_valid & ~i_src_mem & ~i_dst_memw;
            RD_WAIT: begin
                o_uop_ready = i_mem_ack;
                o_mem_req   = 1'b1;
            end
            WR_WAIT: begin
                o_uop_ready = i_mem_ack;
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wdata <= '0;
        end else if (r_state == IDLE && i_uop_valid && i_dst_memw && !i_src_mem) begin
            r_wdata <= i_xbus;
        end
    end

    assign o_mem_wdata = r_wdata;
    assign o_state     = r_state;

endmodule

// File: rtl/datapath_core_gen.sv
// CDEC datapath core: Xbus, PC, GPRs, FLG, MAR/WDR/T/R/I and ALU with a
// valid/ready uop port and req/ack memory. Optional debug mux: DATAPATH_DEBUG_EN.
module datapath_core_gen
    import datapath_pkg::*;
#(
    parameter  int DW   = 8,
    parameter  int NGPR = 3,
    localparam int SELW = $clog2(NGPR + 6)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              uop_valid,
    output logic              uop_ready,
    input  logic [SELW-1:0]   xsrc,
    input  logic [SELW-1:0]   xdst,
    input  logic [ALUOP_W-1:0] aluop,
    input  logic              flg_we,
    output logic [DW-1:0]     I,
    output logic [2:0]        SZCy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_ack,
    input  logic [3:0]        dbg_addr,
    output logic [2*DW-1:0]   dbg_data
);

    localparam logic [SELW-1:0] S_R    = SELW'(src_r(NGPR));
    localparam logic [SELW-1:0] S_MEM  = SELW'(src_mem(NGPR));
    localparam logic [SELW-1:0] S_FLG  = SELW'(src_flg(NGPR));
    localparam logic [SELW-1:0] S_ONES = SELW'(src_ones(NGPR));
    localparam logic [SELW-1:0] D_MAR  = SELW'(dst_mar(NGPR));
    localparam logic [SELW-1:0] D_WDR  = SELW'(dst_wdr(NGPR));
    localparam logic [SELW-1:0] D_T    = SELW'(dst_t(NGPR));
    localparam logic [SELW-1:0] D_I    = SELW'(dst_i(NGPR));
    localparam logic [SELW-1:0] D_MEMW = SELW'(dst_memw(NGPR));

    logic [DW-1:0] r_pc, r_flg, r_mar, r_wdr, r_t, r_r, r_i;
    logic [DW-1:0] r_gpr [1:NGPR];
    logic [DW-1:0] w_xbus, w_alu;
    logic [DW:0]   w_sum;
    logic          w_cin, w_we, w_src_mem, w_dst_memw;
    state_t        w_state;

    assign w_src_mem  = (xsrc == S_MEM);
    assign w_dst_memw = (xdst == D_MEMW);
    assign w_we       = uop_valid & uop_ready;

    dp_mem_if #(.DW(DW)) u_mem_if (
        .clock       (clock),
        .reset       (reset),
        .i_uop_valid (uop_valid),
        .i_src_mem   (w_src_mem),
        .i_dst_memw  (w_dst_memw),
        .i_mem_ack   (mem_ack),
        .i_xbus      (w_xbus),
        .o_uop_ready (uop_ready),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_wdata (mem_wdata),
        .o_state     (w_state)
    );

    always_comb begin
        w_xbus = '0;
        for (int k = 1; k <= NGPR; k++)
            if (xsrc == SELW'(k)) w_xbus = r_gpr[k];
        case (xsrc)
            '0:     w_xbus = r_pc;
            S_R:    w_xbus = r_r;
            S_MEM:  w_xbus = mem_rdata;
            S_FLG:  w_xbus = r_flg;
            S_ONES: w_xbus = '1;
            default: ;
        endcase
    end

    // bit DW of w_sum is carry out (add) or borrow out (subtract)
    assign w_cin = r_flg[FLG_CY];
    always_comb begin
        w_sum = {1'b0, w_xbus};
        case (aluop)
            ALU_ADD:  w_sum = {1'b0, w_xbus} + {1'b0, r_t};
            ALU_ADC:  w_sum = {1'b0, w_xbus} + {1'b0, r_t} + {{DW{1'b0}}, w_cin};
            ALU_SUB:  w_sum = {1'b0, w_xbus} - {1'b0, r_t};
            ALU_SBB:  w_sum = {1'b0, w_xbus} - {1'b0, r_t} - {{DW{1'b0}}, w_cin};
            ALU_AND:  w_sum = {1'b0, w_xbus & r_t};
            ALU_OR:   w_sum = {1'b0, w_xbus | r_t};
            ALU_XOR:  w_sum = {1'b0, w_xbus ^ r_t};
            ALU_NOT:  w_sum = {1'b0, ~w_xbus};
            ALU_PASA: w_sum = {1'b0, w_xbus};
            ALU_PASB: w_sum = {1'b0, r_t};
            ALU_INC:  w_sum = {1'b0, w_xbus} + {{DW{1'b0}}, 1'b1};
            ALU_DEC:  w_sum = {1'b0, w_xbus} - {{DW{1'b0}}, 1'b1};
            ALU_SHL:  w_sum = {w_xbus, 1'b0};
            ALU_SHR:  w_sum = {w_xbus[0], 1'b0, w_xbus[DW-1:1]};
            default: ;
        endcase
    end
    assign w_alu = w_sum[DW-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc  <= '0;
            r_flg <= '0;
            r_mar <= '0;
            r_wdr <= '0;
            r_t   <= '0;
            r_r   <= '0;
            r_i   <= '0;
            for (int k = 1; k <= NGPR; k++) r_gpr[k] <= '0;
        end else if (w_we) begin
            for (int k = 1; k <= NGPR; k++)
                if (xdst == SELW'(k)) r_gpr[k] <= w_xbus;
            case (xdst)
                '0:    r_pc  <= w_xbus;
                D_MAR: r_mar <= w_xbus;
                D_WDR: r_wdr <= w_xbus;
                D_I:   r_i   <= w_xbus;
                D_T: begin
                    r_t <= w_xbus;
                    r_r <= w_alu;
                end
                default: ;
            endcase
            if (flg_we)
                r_flg <= DW'({w_alu[DW-1], (w_alu == '0), w_sum[DW], 1'b0});
        end
    end

    assign I        = r_i;
    assign SZCy     = r_flg[FLG_S:FLG_CY];
    assign mem_addr = r_mar;

`ifdef DATAPATH_DEBUG_EN
    always_comb begin
        dbg_data = '0;
        for (int k = 1; k <= NGPR; k++)
            if (dbg_addr == 4'(k)) dbg_data = {r_gpr[k], r_flg};
        case (dbg_addr)
            4'd0:  dbg_data = {w_xbus, r_pc};
            4'd8:  dbg_data = {r_t, r_r};
            4'd9:  dbg_data = {r_mar, r_wdr};
            4'd10: dbg_data = {mem_rdata, r_i};
            4'd11: dbg_data = (2*DW)'({w_state, xsrc, xdst, aluop});
            default: ;
        endcase
    end
`else
    logic w_unused;
    assign w_unused = ^{dbg_addr, w_state, r_wdr};
    assign dbg_data = '0;
`endif

endmodule

// File: tb/tb_datapath_core_gen.sv
// Bench for datapath_core_gen: directed cases plus random uops checked
// against a behavioural model; a DW=16/NGPR=6 instance covers wide config.
module tb_datapath_core_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        valid = 1'b0, flg_we = 1'b0, mem_ack = 1'b0;
    logic [3:0]  xsrc = '0, xdst = '0, aluop = '0, dbga = '0;
    logic [7:0]  mem_rdata = '0;
    logic        uop_ready, mem_req, mem_we;
    logic [7:0]  I_o, mem_addr, mem_wdata;
    logic [2:0]  szcy;
    logic [15:0] dbg;

    logic        b_valid = 1'b0, b_fw = 1'b0, b_ack = 1'b0;
    logic [3:0]  b_xsrc = '0, b_xdst = '0, b_aluop = '0, b_dbga = '0;
    logic [15:0] b_rdata = '0;
    logic        b_ready, b_req, b_we;
    logic [15:0] b_I, b_addr, b_wdata;
    logic [2:0]  b_szcy;
    logic [31:0] b_dbg;

    datapath_core_gen u0 (
        .clock(clk), .reset(rst_n), .uop_valid(valid), .uop_ready(uop_ready),
        .xsrc(xsrc), .xdst(xdst), .aluop(aluop), .flg_we(flg_we),
        .I(I_o), .SZCy(szcy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .dbg_addr(dbga), .dbg_data(dbg)
    );

    datapath_core_gen #(.DW(16), .NGPR(6)) u1 (
        .clock(clk), .reset(rst_n), .uop_valid(b_valid), .uop_ready(b_ready),
        .xsrc(b_xsrc), .xdst(b_xdst), .aluop(b_aluop), .flg_we(b_fw),
        .I(b_I), .SZCy(b_szcy), .mem_req(b_req), .mem_we(b_we),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
        .mem_ack(b_ack), .dbg_addr(b_dbga), .dbg_data(b_dbg)
    );

    int total = 0;
    int bad = 0;

    int mPC, mMAR, mWDR, mT, mR, mI, mFLG, mWD;
    int mG [1:3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mPC = 0; mMAR = 0; mWDR = 0; mT = 0; mR = 0; mI = 0; mFLG = 0; mWD = 0;
        for (int k = 1; k <= 3; k++) mG[k] = 0;
    endtask

    function automatic int xbus_m(int s, int rd);
        case (s)
            0:       return mPC;
            1, 2, 3: return mG[s];
            4:       return mR;
            5:       return rd;
            6:       return mFLG;
            7:       return 'hFF;
            default: return 0;
        endcase
    endfunction

    // returns {carry, result[7:0]} for a = Xbus, b = T
    function automatic int alu_m(int op, int a, int b, int cin);
        int r, c;
        c = 0;
        case (op)
            0:  begin r = a + b;       c = (r > 255) ? 1 : 0; end
            1:  begin r = a + b + cin; c = (r > 255) ? 1 : 0; end
            2:  begin r = a - b;       c = (a < b) ? 1 : 0; end
            3:  begin r = a - b - cin; c = (a < b + cin) ? 1 : 0; end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  r = ~a;
            9:  r = b;
            10: begin r = a + 1;       c = (a == 255) ? 1 : 0; end
            11: begin r = a - 1;       c = (a == 0) ? 1 : 0; end
            12: begin r = a * 2;       c = a / 128; end
            13: begin r = a / 2;       c = a % 2; end
            default: r = a;
        endcase
        return (c * 256) + (r & 'hFF);
    endfunction

    task automatic do_uop(input int s, input int d, input int op, input int fw,
                          input int dly, input int rd);
        int x, ar, r, cy, z, memop, wr;
        memop = (s == 5 || d == 8) ? 1 : 0;
        wr    = (d == 8 && s != 5) ? 1 : 0;
        @(negedge clk);
        valid = 1'b1; xsrc = 4'(s); xdst = 4'(d); aluop = 4'(op);
        flg_we = fw[0]; mem_ack = 1'b0;
        x = xbus_m(s, rd);
        #1;
        if (memop == 0) begin
            chk("ready_comb", uop_ready, 1);
            chk("req_idle", mem_req, 0);
        end else begin
            chk("ready_req", uop_ready, 0);
            if (wr != 0) mWD = x;
            for (int k = 1; k <= dly; k++) begin
                @(negedge clk);
                chk("req_hold", mem_req, 1);
                chk("mem_we", mem_we, wr);
                chk("mem_addr", mem_addr, mMAR);
                if (wr != 0) chk("mem_wdata", mem_wdata, mWD);
                if (k == dly) begin
                    mem_ack = 1'b1; mem_rdata = 8'(rd);
                    #1 chk("ready_ack", uop_ready, 1);
                end else begin
                    #1 chk("ready_wait", uop_ready, 0);
                end
            end
        end
        @(posedge clk);
        ar = alu_m(op, x, mT, (mFLG / 2) % 2);
        r  = ar % 256;
        cy = ar / 256;
        z  = (r == 0) ? 1 : 0;
        case (d)
            0:       mPC = x;
            1, 2, 3: mG[d] = x;
            4:       mMAR = x;
            5:       mWDR = x;
            6:       begin mR = r; mT = x; end
            7:       mI = x;
            default: ;
        endcase
        if (fw != 0) mFLG = (r / 128) * 8 + z * 4 + cy * 2;
        @(negedge clk);
        valid = 1'b0; mem_ack = 1'b0;
        #1;
        chk("req_after", mem_req, 0);
        chk("ready_after", uop_ready, 0);
        chk("mar", mem_addr, mMAR);
        chk("I", I_o, mI);
        chk("SZCy", szcy, (mFLG / 2) % 8);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_ready", uop_ready, 0);
        chk("rst_I", I_o, 0);
        chk("rst_szcy", szcy, 0);
        chk("rst_mar", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_b_req", b_req, 0);
        rst_n = 1'b1;

        // 1: all-ones into R1 in a single cycle
        do_uop(7, 1, 8, 0, 1, 0);
        do_uop(1, 4, 8, 0, 1, 0);
        chk("t1_r1", mem_addr, 8'hFF);

        // 2: read from MAR=10 with a 3-cycle ack
        do_uop(5, 4, 8, 0, 1, 'h10);
        do_uop(5, 2, 8, 0, 3, 'h3C);
        do_uop(2, 7, 8, 0, 1, 0);
        chk("t2_r2", I_o, 8'h3C);

        // 3: write R1=5A, ack after 2 cycles
        do_uop(5, 1, 8, 0, 1, 'h5A);
        do_uop(1, 8, 8, 0, 2, 0);
        chk("t3_wdata", mem_wdata, 8'h5A);

        // 4: T=FF, R1=01, ADD into T with flags
        do_uop(7, 6, 8, 0, 1, 0);
        do_uop(5, 1, 8, 0, 1, 'h01);
        do_uop(1, 6, 0, 1, 1, 0);
        chk("t4_szcy", szcy, 3'b011);
        dbga = 4'd8;
        #1;
`ifdef DATAPATH_DEBUG_EN
        chk("t4_dbg_tr", dbg, 16'h0100);
`else
        chk("t4_dbg_off", dbg, 16'h0000);
`endif
        do_uop(4, 4, 8, 0, 1, 0);
        chk("t4_r", mem_addr, 8'h00);

        for (int n = 0; n < 250; n++)
            do_uop($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 1), $urandom_range(1, 3), $urandom_range(0, 255));

        // stray ack while idle must not start or finish anything
        @(negedge clk);
        mem_ack = 1'b1;
        #1 chk("stray_ready", uop_ready, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1 chk("stray_req", mem_req, 0);
        chk("stray_mar", mem_addr, mMAR);

        // 5: async reset in the middle of a read
        do_uop(5, 4, 8, 0, 1, 'hA7);
        @(negedge clk);
        valid = 1'b1; xsrc = 4'd5; xdst = 4'd1; aluop = 4'd8; flg_we = 1'b0;
        @(negedge clk);
        #1 chk("t5_req_on", mem_req, 1);
        #1 rst_n = 1'b0;
        #1 chk("t5_req_async", mem_req, 0);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("t5_mar", mem_addr, 0);
        chk("t5_I", I_o, 0);
        chk("t5_szcy", szcy, 0);
        chk("t5_wdata", mem_wdata, 0);
        chk("t5_ready", uop_ready, 0);
        for (int s = 0; s <= 6; s++) begin
            if (s != 5) begin
                do_uop(s, 4, 8, 0, 1, 0);
                chk("t5_zero", mem_addr, 0);
            end
        end
        do_uop(7, 6, 9, 0, 1, 0);
        do_uop(4, 7, 8, 0, 1, 0);
        chk("t5_t_old", I_o, 0);

        // 6: wide instance, BEEF through R6 into MAR
        @(negedge clk);
        b_valid = 1'b1; b_xsrc = 4'd8; b_xdst = 4'd6; b_aluop = 4'd8;
        #1 chk("t6_ready_lo", b_ready, 0);
        @(negedge clk);
        chk("t6_req", b_req, 1);
        b_ack = 1'b1; b_rdata = 16'hBEEF;
        #1 chk("t6_ready_ack", b_ready, 1);
        @(negedge clk);
        b_ack = 1'b0; b_xsrc = 4'd6; b_xdst = 4'd7;
        #1 chk("t6_ready_mar", b_ready, 1);
        @(negedge clk);
        b_valid = 1'b0; b_dbga = 4'd6;
        #1;
        chk("t6_addr", b_addr, 16'hBEEF);
        chk("t6_req_off", b_req, 0);
`ifdef DATAPATH_DEBUG_EN
        chk("t6_dbg", b_dbg, 32'hBEEF_0000);
`else
        chk("t6_dbg_off", b_dbg, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
